// File: rtl/prog_seq_det_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
// Holds the reset-time pattern defaults and the length-mask function.
package prog_seq_det_pkg;

  localparam logic [7:0] DEF_RST_PATTERN = 8'b0000_1011;
  localparam int         DEF_RST_LEN     = 4;
  localparam bit         DEF_RST_OVERLAP = 1'b1;

  localparam int MASK_W = 32;

  function automatic logic [MASK_W-1:0] len_mask(
    input int unsigned len
  );
    if (len >= MASK_W) return '1;
    return (MASK_W'(1) << len) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Holds at all-ones once reached instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_seq_detector.sv
// Runtime-programmable serial pattern detector with Mealy strobe,
// registered strobe and saturating match counter.
module prog_seq_detector
  import prog_seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
  parameter int                 RST_LEN     = DEF_RST_LEN,
  parameter bit                 RST_OVERLAP = DEF_RST_OVERLAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x_valid,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_L = LEN_W'(RST_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               match_q_d;

  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   eff_len;
  logic [LEN_W-1:0]   fill_inc;
  logic               consume;
  logic               hit;

  assign shifted  = {hist_q[MAX_LEN-2:0], x};
  assign mask     = MAX_LEN'(len_mask(32'(len_q)));
  assign eff_len  = (cfg_len > MAX_L) ? MAX_L : cfg_len;
  assign fill_inc = (fill_q == MAX_L) ? MAX_L : fill_q + LEN_W'(1);
  assign consume  = x_valid && !cfg_load && !rst;

  // Require len-1 stored bits so that masked-in history is all fresh.
  assign hit = (len_q != '0)
            && (fill_q >= len_q - LEN_W'(1))
            && ((shifted & mask) == (pat_q & mask));

  assign match = consume && hit;

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    match_q_d = match;
    if (cfg_load) begin
      hist_d    = '0;
      fill_d    = '0;
      pat_d     = cfg_pattern;
      len_d     = eff_len;
      ovl_d     = cfg_overlap;
      match_q_d = 1'b0;
    end else if (x_valid) begin
      hist_d = shifted;
      fill_d = (match && !ovl_q) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= RST_PATTERN;
      len_q   <= RST_L;
      ovl_q   <= RST_OVERLAP;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      match_q <= match_q_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr_i(cfg_load),
    .inc_i(match),
    .cnt_o(match_count)
  );

endmodule

// File: tb/tb_prog_seq_detector.sv
// Bench for prog_seq_detector: directed scenarios plus random traffic
// against a bit-queue reference model; a second CNT_W=2 copy checks saturation.
module tb_prog_seq_detector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_valid = 1'b0;
  logic        x = 1'b0;
  logic        cfg_load = 1'b0;
  logic [7:0]  cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic        cfg_overlap = 1'b0;
  logic        match, match_q;
  logic [15:0] match_count;
  logic        match2, match_q2;
  logic [1:0]  count2;

  int nchk = 0;
  int nerr = 0;

  bit       mbits[$];
  bit [7:0] mpat;
  int       mlen;
  bit       movl;
  bit       mmq;
  int       mcnt;
  int       mcnt2;

  always #5 clk = ~clk;

  prog_seq_detector dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .match(match), .match_q(match_q), .match_count(match_count)
  );

  prog_seq_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .match(match2), .match_q(match_q2), .match_count(count2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Pattern matches when the newest mlen bits (incl. xb) equal pat.
  function automatic bit model_match(input bit xb);
    bit w[$];
    w = mbits;
    w.push_back(xb);
    if (mlen == 0 || w.size() < mlen) return 1'b0;
    for (int i = 0; i < mlen; i++)
      if (w[w.size() - mlen + i] != mpat[mlen-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit r, input bit ld, input bit v,
                      input bit xb, input logic [7:0] cp,
                      input logic [3:0] cl, input bit co);
    bit e;
    @(negedge clk);
    rst = r; cfg_load = ld; x_valid = v; x = xb;
    cfg_pattern = cp; cfg_len = cl; cfg_overlap = co;
    e = !r && !ld && v && model_match(xb);
    #1;
    chk("match", match, e);
    chk("match_c2", match2, e);
    @(posedge clk);
    if (r) begin
      mbits.delete();
      mpat = 8'h0B; mlen = 4; movl = 1'b1;
      mmq = 1'b0; mcnt = 0; mcnt2 = 0;
    end else if (ld) begin
      mbits.delete();
      mpat = cp; mlen = (cl > 8) ? 8 : int'(cl); movl = co;
      mmq = 1'b0; mcnt = 0; mcnt2 = 0;
    end else begin
      mmq = e;
      if (v) begin
        if (e && !movl) mbits.delete();
        else begin
          mbits.push_back(xb);
          if (mbits.size() > 8) void'(mbits.pop_front());
        end
      end
      if (e) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt2 < 3) mcnt2++;
      end
    end
    #1;
    chk("match_q", match_q, mmq);
    chk("match_q_c2", match_q2, mmq);
    chk("count", match_count, mcnt);
    chk("count_c2", count2, mcnt2);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 8'h00, 4'd0, 0);
  endtask

  task automatic bitv(input bit xb);
    step(0, 0, 1, xb, 8'h00, 4'd0, 0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l,
                      input bit o);
    step(0, 1, 0, 0, p, l, o);
  endtask

  task automatic reset_cyc();
    step(1, 0, 0, 0, 8'h00, 4'd0, 0);
  endtask

  task automatic feed(input logic [15:0] bits, input int n,
                      input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      bitv(bits[i]);
      repeat (gap) idle();
    end
  endtask

  initial begin
    reset_cyc();
    reset_cyc();
    chk("rst_count", match_count, 0);
    chk("rst_match_q", match_q, 0);

    feed(16'b1011011, 7, 0);
    chk("ovl_default_cnt", match_count, 2);

    load(8'h0B, 4'd4, 1'b0);
    feed(16'b1011011, 7, 0);
    chk("nonovl_cnt", match_count, 1);

    load(8'h07, 4'd3, 1'b1);
    feed(16'b11111, 5, 2);
    chk("gap_cnt", match_count, 3);

    load(8'h0B, 4'd0, 1'b1);
    feed(16'b1011, 4, 0);
    chk("len0_cnt", match_count, 0);

    load(8'hA5, 4'd12, 1'b1);
    feed(16'hA5, 8, 0);
    chk("len_clip_cnt", match_count, 1);
    feed(16'b0101, 4, 0);
    chk("len_clip_tail", match_count, 1);

    load(8'h0B, 4'd4, 1'b1);
    feed(16'b101, 3, 0);
    step(0, 1, 1, 1, 8'h0B, 4'd4, 1'b1);
    chk("load_wins_cnt", match_count, 0);

    feed(16'b101, 3, 0);
    reset_cyc();
    bitv(1'b1);
    chk("rst_mid_cnt", match_count, 0);
    feed(16'b011, 3, 0);
    chk("rst_fresh_cnt", match_count, 1);

    load(8'h03, 4'd2, 1'b1);
    feed(16'b111111, 6, 0);
    chk("sat_c2", count2, 3);
    chk("sat_c16", match_count, 5);

    repeat (2000) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 2) reset_cyc();
      else if (r < 7) begin
        logic [3:0] l;
        l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                        : 4'($urandom_range(1, 4));
        load(8'($urandom), l, 1'($urandom));
      end else if (r < 60) idle();
      else bitv(1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
